// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state type, default timing constants and timer width helper for the alarm ring controller.
package alarm_pkg;
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} ring_state_t;
  localparam int DEF_RING_TIMEOUT_S = 60;
  localparam int DEF_SNOOZE_S = 300;
  localparam int DEF_MAX_SNOOZE = 3;
  function automatic int timer_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/sec_down_counter.sv
// sec_down_counter: loadable seconds counter that counts down on tick, stops at 1, and pulses expire on the last tick.
module sec_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (tick && count > W'(1)) count <= count - W'(1);
  assign expire = tick && count == W'(1);
endmodule

// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller: turns an alarm match into a ringing session with snooze, stop and auto-off.
module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int SNOOZE_S       = DEF_SNOOZE_S,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick_1hz,
  input  logic                            aa,
  input  logic                            snooze_btn,
  input  logic                            stop_btn,
  output logic                            buzzer,
  output logic                            ringing,
  output logic                            snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_count
);
  localparam int TW = timer_w(RING_TIMEOUT_S, SNOOZE_S);
  localparam int SW = $clog2(MAX_SNOOZE + 1);
  ring_state_t state, state_n;
  logic aa_q, beep, beep_n, ev, load, expire;
  logic [SW-1:0] cnt_n;
  logic [TW-1:0] load_val, timer;
  assign ev = aa & ~aa_q;
  sec_down_counter #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .tick(tick_1hz), .count(timer), .expire(expire)
  );
  always_comb begin
    state_n = state;
    beep_n = beep;
    cnt_n = snooze_count;
    load = 1'b0;
    load_val = TW'(RING_TIMEOUT_S);
    case (state)
      IDLE:
        if (ev) begin
          state_n = RING;
          load = 1'b1;
          beep_n = 1'b1;
          cnt_n = '0;
        end
      RING:
        if (stop_btn) state_n = IDLE;
        else if (snooze_btn && snooze_count < SW'(MAX_SNOOZE)) begin
          state_n = SNOOZE;
          load = 1'b1;
          load_val = TW'(SNOOZE_S);
          cnt_n = snooze_count + SW'(1);
        end
        else if (expire) state_n = IDLE;
        else if (tick_1hz) beep_n = ~beep;
      SNOOZE:
        if (stop_btn) state_n = IDLE;
        else if (ev || expire) begin
          state_n = RING;
          load = 1'b1;
          beep_n = 1'b1;
          cnt_n = ev ? '0 : snooze_count;
        end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) begin
      beep_n = 1'b0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      aa_q <= 1'b0;
      beep <= 1'b0;
      snooze_count <= '0;
    end else begin
      state <= state_n;
      aa_q <= aa;
      beep <= beep_n;
      snooze_count <= cnt_n;
    end
  // a live session always holds a loaded, non-zero timer
  always_ff @(posedge clk)
    if (!rst && state != IDLE) assert (timer != '0);
  assign ringing = state == RING;
  assign snoozing = state == SNOOZE;
  assign buzzer = ringing & beep;
endmodule

// File: tb/tb_alarm_ring_controller.sv
// tb_alarm_ring_controller: scoreboard bench comparing the controller against a seconds-level session model.
module tb_alarm_ring_controller;
  localparam int RT = 4, SN = 3, MX = 2;
  logic clk = 0, rst = 1, tick_1hz = 0, aa = 0, snooze_btn = 0, stop_btn = 0;
  logic buzzer, ringing, snoozing;
  logic [1:0] snooze_count;
  typedef struct packed {logic r, s, b; logic [1:0] c;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  bit m_ring, m_snz, m_aa_prev;
  int m_elapsed, m_left, m_cnt;

  alarm_ring_controller #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SN), .MAX_SNOOZE(MX)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .aa(aa), .snooze_btn(snooze_btn),
    .stop_btn(stop_btn), .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic a, input logic s, input logic p, input logic t, input logic r);
    bit ev;
    @(negedge clk);
    aa = a; snooze_btn = s; stop_btn = p; tick_1hz = t; rst = r;
    ev = a && !m_aa_prev;
    m_aa_prev = r ? 1'b0 : a;
    if (r) begin
      m_ring = 0; m_snz = 0; m_cnt = 0;
    end else if (m_ring) begin
      if (p) m_ring = 0;
      else if (s && m_cnt < MX) begin
        m_ring = 0; m_snz = 1; m_left = SN; m_cnt++;
      end else if (t) begin
        m_elapsed++;
        if (m_elapsed == RT) m_ring = 0;
      end
    end else if (m_snz) begin
      if (p) m_snz = 0;
      else if (ev) begin
        m_snz = 0; m_ring = 1; m_elapsed = 0; m_cnt = 0;
      end else if (t) begin
        m_left--;
        if (m_left == 0) begin
          m_snz = 0; m_ring = 1; m_elapsed = 0;
        end
      end
    end else if (ev) begin
      m_ring = 1; m_elapsed = 0; m_cnt = 0;
    end
    if (!m_ring && !m_snz) m_cnt = 0;
    q.push_back('{m_ring, m_snz, m_ring && (m_elapsed % 2 == 0), 2'(m_cnt)});
  endtask

  task automatic idle(input int n, input logic a);
    for (int i = 0; i < n; i++) step(a, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input logic a);
    for (int i = 0; i < n; i++) begin
      idle(2, a);
      step(a, 0, 0, 1, 0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({ringing, snoozing, buzzer, snooze_count} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got ringing=%b snoozing=%b buzzer=%b count=%0d want ringing=%b snoozing=%b buzzer=%b count=%0d",
                 $time, ringing, snoozing, buzzer, snooze_count, e.r, e.s, e.b, e.c);
      end
    end
  end

  initial begin
    logic ra;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(8, 0);
    idle(1, 1);
    ticks(6, 1);
    idle(20, 1);
    idle(1, 0);
    idle(1, 1);
    ticks(1, 1);
    step(1, 1, 0, 0, 0);
    ticks(3, 1);
    idle(2, 1);
    step(1, 1, 0, 0, 0);
    ticks(3, 1);
    step(1, 1, 0, 0, 0);
    idle(1, 1);
    step(1, 0, 1, 0, 0);
    idle(1, 0);
    idle(1, 1);
    step(1, 1, 1, 0, 0);
    idle(1, 0);
    idle(1, 1);
    ticks(3, 1);
    idle(2, 1);
    step(1, 1, 0, 1, 0);
    ticks(2, 1);
    step(1, 0, 1, 0, 0);
    idle(1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    idle(1, 0);
    idle(1, 1);
    ticks(4, 1);
    idle(2, 1);
    idle(1, 0);
    idle(1, 1);
    ticks(1, 1);
    step(1, 0, 0, 0, 1);
    idle(4, 1);
    ra = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) ra = ~ra;
      step(ra, $urandom_range(11) == 0, $urandom_range(39) == 0,
           $urandom_range(5) == 0, $urandom_range(499) == 0);
    end
    idle(2, 0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
